tag_seq: RTL and testbench
==========================

# tag_seq

Tag sequencer that sits directly upstream of the column tag allocator in the convolution array. It accepts one job descriptor at a time over a valid/ready handshake. For each job it issues a run of consecutive tags, each as a one-cycle `flush` strobe with `tag_in` set to the tag value. It drives the per-column `tag_lock` mask for the whole job, including a drain window long enough for the last tag to ripple through all `NUM_COL` columns, and then signals completion.

## Interface
- `NUM_COL`, default 8: number of array columns; sets the width of `tag_lock` and the length of the drain window.
- `DATA_WIDTH`, default 32: tag width.
- `CNT_WIDTH`, default 16: width of the tag-count and hold-count fields.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  descriptor valid.
- `cfg_ready`  out  1  descriptor ready; high only in IDLE.
- `cfg_num_tags`  in  CNT_WIDTH  number of tags N to issue.
- `cfg_hold`  in  CNT_WIDTH  idle cycles H inserted after each flush.
- `cfg_base_tag`  in  DATA_WIDTH  first tag value.
- `cfg_col_mask`  in  NUM_COL  column enable mask, driven on `tag_lock`.
- `abort`  in  1  synchronous job kill.
- `tag_in`  out  DATA_WIDTH  current tag, feeds the allocator.
- `flush`  out  1  one-cycle load strobe for `tag_in`.
- `tag_lock`  out  NUM_COL  column enable mask.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, HOLD, DRAIN, DONE. All outputs are registered or decoded from registered state.
- **Accept:** a descriptor is accepted when `cfg_valid && cfg_ready`. At that edge the block latches N, H, base and mask, and loads the tag counter with base.
  - N = 0: next state is DONE.
  - N > 0: next state is ISSUE.
- **ISSUE (1 cycle):**
  - `flush` = 1, `tag_in` = tag counter value.
  - The tag counter increments modulo 2^DATA_WIDTH; 0xFFFFFFFF wraps to 0.
  - The issued-tag count increments.
  - Next state: if H > 0, go to HOLD with the hold counter loaded to H. Otherwise go to ISSUE if tags remain, else DRAIN.
- **HOLD (H cycles):** `flush` = 0. On the final hold cycle, go to ISSUE if tags remain, else DRAIN.
- **DRAIN (exactly NUM_COL cycles):** `flush` = 0, `tag_lock` stays at the mask.
- **DONE (1 cycle):** `done` = 1, `tag_lock` = 0, `cfg_ready` = 0. Next state is IDLE.
- `tag_lock` equals the latched mask in ISSUE, HOLD and DRAIN, and is 0 in IDLE and DONE.
- `tag_in` holds the last issued value between flushes and across jobs. Only reset clears it.
- `cfg_valid` outside IDLE is ignored; descriptor inputs are sampled only at acceptance.
- **abort:** takes priority over all other transitions. In any non-IDLE state the next state is IDLE, with `flush`, `tag_lock` and `done` all 0; no `done` pulse is produced. Abort in IDLE is a no-op. If `abort` and `cfg_valid` coincide in IDLE, the descriptor is accepted.
- **Reset:** state = IDLE, `tag_in` = 0, `flush` = 0, `tag_lock` = 0, `busy` = 0, `done` = 0, all counters 0. `cfg_ready` goes high as soon as `rst` deasserts. Reset mid-job discards the job silently.

## Timing
- With acceptance at edge T (cycle 0):
  - Tag k (k = 0 … N−1) is flushed in cycle 1 + k·(H+1).
  - The last flush is L = 1 + (N−1)(H+1). HOLD occupies L+1 … L+H.
  - DRAIN occupies L+H+1 … L+H+NUM_COL.
  - DONE is cycle L+H+NUM_COL+1, and `cfg_ready` = 1 in the following cycle.
- The earliest re-acceptance is the cycle after DONE. There is no back-to-back overlap between jobs.
- N = 0: DONE in cycle 1, IDLE in cycle 2, and `flush` never asserts.
- H = 0: `flush` stays high for N consecutive cycles, with `tag_in` incrementing every cycle.
- Abort sampled in cycle c: the outputs are quiet and `cfg_ready` = 1 from cycle c+1.

## Test plan
- **Basic job.** NUM_COL=8, N=3, H=1, base=0x10, mask=0xFF accepted at cycle 0. Required: `flush` in cycles 1, 3, 5 with `tag_in` 0x10, 0x11, 0x12; `tag_lock`=0xFF in cycles 1–14; `done` in cycle 15; `cfg_ready` in cycle 16.
- **Back-to-back flushes.** N=4, H=0, base=0x0. Required: `flush` high in cycles 1–4 with tags 0–3; DRAIN in cycles 5–12; `done` in cycle 13.
- **Tag wrap.** N=2, H=0, base=0xFFFFFFFF. Required: tags 0xFFFFFFFF then 0x00000000; `tag_in` holds 0x0 after the job.
- **Empty job.** N=0, mask=0x0F. Required: no `flush`; `tag_lock` stays 0; `done` in cycle 1; `cfg_ready` in cycle 2.
- **Abort and ignored descriptor.** Abort in cycle 4 of the basic job. Required: `flush`=`tag_lock`=`done`=0 and `cfg_ready`=1 from cycle 5 with no `done` pulse. A second `cfg_valid` held during the job before the abort must not be accepted.
- **Reset.** Assert `rst` mid-HOLD. Required: all outputs reset immediately, with no clock edge needed; after deassert, a new job runs the basic-job timeline correctly.

Source files
------------

// File: rtl/tag_seq.sv
// tag_seq: issues a run of consecutive tags to the column tag allocator.
// It accepts one job descriptor at a time over a valid/ready handshake.
// Each tag goes out as a one-cycle flush strobe, followed by H hold cycles.
// The column lock mask stays up for the whole job, including a drain window
// of NUM_COL cycles that lets the last tag ripple across the array.
// A one-cycle done pulse closes the job; abort kills a job without one.

module tag_seq #(
    parameter int NUM_COL    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CNT_WIDTH-1:0]  cfg_num_tags,
    input  logic [CNT_WIDTH-1:0]  cfg_hold,
    input  logic [DATA_WIDTH-1:0] cfg_base_tag,
    input  logic [NUM_COL-1:0]    cfg_col_mask,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] tag_in,
    output logic                  flush,
    output logic [NUM_COL-1:0]    tag_lock,
    output logic                  busy,
    output logic                  done
);

    // The drain counter must be able to hold the value NUM_COL itself.
    localparam int DRW = $clog2(NUM_COL + 1);

    localparam logic [DRW-1:0]        DRAIN_LEN = DRW'(NUM_COL);
    localparam logic [DRW-1:0]        DRAIN_ONE = DRW'(1);
    localparam logic [DRW-1:0]        DRAIN_ZERO = DRW'(0);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = CNT_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] TAG_ONE   = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] TAG_ZERO  = DATA_WIDTH'(0);
    localparam logic [NUM_COL-1:0]    MASK_ZERO = NUM_COL'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_r;

    // Descriptor fields captured at acceptance; the inputs are not looked at
    // again until the block is back in IDLE.
    logic [CNT_WIDTH-1:0]  num_r;
    logic [CNT_WIDTH-1:0]  hold_r;
    logic [NUM_COL-1:0]    mask_r;

    // tag_cnt_r always holds the next tag to be issued; tag_in_r is the
    // value presented to the allocator and only changes on entry to ISSUE.
    logic [DATA_WIDTH-1:0] tag_cnt_r;
    logic [DATA_WIDTH-1:0] tag_in_r;
    logic [CNT_WIDTH-1:0]  issued_r;
    logic [CNT_WIDTH-1:0]  hold_cnt_r;
    logic [DRW-1:0]        drain_cnt_r;

    logic [CNT_WIDTH-1:0]  issued_inc_s;
    logic                  more_after_issue_s;
    logic                  more_s;
    logic                  flush_s;
    logic                  done_s;
    logic                  busy_s;
    logic                  lock_en_s;

    // True while fewer than the requested number of tags have gone out.
    function automatic logic tags_remain(
        input logic [CNT_WIDTH-1:0] issued,
        input logic [CNT_WIDTH-1:0] total
    );
        return (issued < total);
    endfunction

    // Remaining-tag decisions for the ISSUE and HOLD exits.
    always_comb begin
        issued_inc_s       = issued_r + CNT_ONE;
        more_after_issue_s = tags_remain(issued_inc_s, num_r);
        more_s             = tags_remain(issued_r, num_r);
    end

    // Sequencer FSM with its counters and the tag output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            num_r       <= CNT_ZERO;
            hold_r      <= CNT_ZERO;
            mask_r      <= MASK_ZERO;
            tag_cnt_r   <= TAG_ZERO;
            tag_in_r    <= TAG_ZERO;
            issued_r    <= CNT_ZERO;
            hold_cnt_r  <= CNT_ZERO;
            drain_cnt_r <= DRAIN_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // Abort is a no-op here, so a coincident descriptor is
                    // still taken.
                    if (cfg_valid) begin
                        num_r     <= cfg_num_tags;
                        hold_r    <= cfg_hold;
                        mask_r    <= cfg_col_mask;
                        tag_cnt_r <= cfg_base_tag;
                        issued_r  <= CNT_ZERO;
                        if (cfg_num_tags == CNT_ZERO) begin
                            state_r <= S_DONE;
                        end else begin
                            state_r  <= S_ISSUE;
                            tag_in_r <= cfg_base_tag;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_ISSUE: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                    end else begin
                        // Natural wrap at 2^DATA_WIDTH.
                        tag_cnt_r <= tag_cnt_r + TAG_ONE;
                        issued_r  <= issued_inc_s;
                        if (hold_r != CNT_ZERO) begin
                            state_r    <= S_HOLD;
                            hold_cnt_r <= hold_r;
                        end else if (more_after_issue_s) begin
                            state_r  <= S_ISSUE;
                            tag_in_r <= tag_cnt_r + TAG_ONE;
                        end else begin
                            state_r     <= S_DRAIN;
                            drain_cnt_r <= DRAIN_LEN;
                        end
                    end
                end

                S_HOLD: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                    end else if (hold_cnt_r == CNT_ONE) begin
                        // Last hold cycle: tag_cnt_r already points at the
                        // next tag.
                        if (more_s) begin
                            state_r  <= S_ISSUE;
                            tag_in_r <= tag_cnt_r;
                        end else begin
                            state_r     <= S_DRAIN;
                            drain_cnt_r <= DRAIN_LEN;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r - CNT_ONE;
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                    end else if (drain_cnt_r == DRAIN_ONE) begin
                        state_r <= S_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
                    end
                end

                S_DONE: begin
                    state_r <= S_IDLE;
                end

                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Output strobes and lock enable decoded from the registered state.
    always_comb begin
        flush_s   = 1'b0;
        done_s    = 1'b0;
        busy_s    = 1'b1;
        lock_en_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_s = 1'b0;
            end
            S_ISSUE: begin
                flush_s   = 1'b1;
                lock_en_s = 1'b1;
            end
            S_HOLD: begin
                lock_en_s = 1'b1;
            end
            S_DRAIN: begin
                lock_en_s = 1'b1;
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Ready is held low while reset is asserted so it rises with deassertion.
    assign cfg_ready = (state_r == S_IDLE) && !rst;
    assign tag_in    = tag_in_r;
    assign flush     = flush_s;
    assign done      = done_s;
    assign busy      = busy_s;
    assign tag_lock  = lock_en_s ? mask_r : MASK_ZERO;

endmodule

// File: tb/tb_tag_seq.sv
// Randomised scoreboard bench for tag_seq. The driver builds the expected
// flush/done timeline from the cycle formulas of each job and queues it; a
// negedge monitor pops and compares whenever the DUT strobes, and also
// checks the lock mask, busy, ready and the held tag every cycle.

module tb_tag_seq;

    localparam int NUM_COL    = 8;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;
    localparam int NO_ABORT   = 32'h7fff_ffff;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [CNT_WIDTH-1:0]  cfg_num_tags = '0;
    logic [CNT_WIDTH-1:0]  cfg_hold = '0;
    logic [DATA_WIDTH-1:0] cfg_base_tag = '0;
    logic [NUM_COL-1:0]    cfg_col_mask = '0;
    logic                  abort = 1'b0;
    logic [DATA_WIDTH-1:0] tag_in;
    logic                  flush;
    logic [NUM_COL-1:0]    tag_lock;
    logic                  busy;
    logic                  done;

    tag_seq #(
        .NUM_COL   (NUM_COL),
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_num_tags(cfg_num_tags),
        .cfg_hold    (cfg_hold),
        .cfg_base_tag(cfg_base_tag),
        .cfg_col_mask(cfg_col_mask),
        .abort       (abort),
        .tag_in      (tag_in),
        .flush       (flush),
        .tag_lock    (tag_lock),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] tag;
    } flush_t;

    flush_t      flush_q[$];
    int          done_q[$];
    flush_t      mon_e;
    int          mon_d;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    // Reference job description (one job at a time).
    bit          job_active = 1'b0;
    int          job_c0 = 0;
    int          job_end = 0;
    int          job_abort_c = NO_ABORT;
    int          job_n = 0;
    logic [7:0]  job_mask = '0;
    logic [31:0] exp_tag_in = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Offset from the acceptance cycle to the DONE cycle.
    function automatic int done_offset(input int n, input int h);
        if (n == 0) return 1;
        return 1 + (n - 1) * (h + 1) + h + NUM_COL + 1;
    endfunction

    function automatic logic exp_busy(input int c);
        return job_active && (c > job_c0) && (c <= job_end) && (c <= job_abort_c);
    endfunction

    function automatic logic [7:0] exp_lock(input int c);
        if (job_active && job_n > 0 && c > job_c0 && c < job_end && c <= job_abort_c)
            return job_mask;
        return 8'h00;
    endfunction

    task automatic model_accept(input int c, input int n, input int h,
                                input logic [31:0] base, input logic [7:0] mask);
        flush_t e;
        job_active  = 1'b1;
        job_c0      = c;
        job_n       = n;
        job_mask    = mask;
        job_end     = c + done_offset(n, h);
        job_abort_c = NO_ABORT;
        for (int k = 0; k < n; k++) begin
            e.cyc = c + 1 + k * (h + 1);
            e.tag = base + 32'(k);
            flush_q.push_back(e);
        end
        done_q.push_back(job_end);
    endtask

    task automatic model_abort(input int c);
        job_abort_c = c;
        while (flush_q.size() > 0 && flush_q[flush_q.size()-1].cyc > c) flush_q.pop_back();
        while (done_q.size() > 0 && done_q[done_q.size()-1] > c) done_q.pop_back();
    endtask

    task automatic model_reset();
        flush_q.delete();
        done_q.delete();
        job_active = 1'b0;
        exp_tag_in = '0;
    endtask

    // Monitor: consumes expected strobes and checks per-cycle levels.
    always @(negedge clk) begin
        if (flush === 1'b1) begin
            if (flush_q.size() == 0) begin
                check("flush_unexpected", 64'(flush), 64'd0);
            end else begin
                mon_e = flush_q.pop_front();
                check("flush_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("flush_tag", 64'(tag_in), 64'(mon_e.tag));
                exp_tag_in = mon_e.tag;
            end
        end else if (flush_q.size() > 0 && flush_q[0].cyc <= cyc) begin
            check("flush_missing", 64'(flush), 64'd1);
            mon_e = flush_q.pop_front();
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'd0);
            end else begin
                mon_d = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_d));
            end
        end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
            check("done_missing", 64'(done), 64'd1);
            mon_d = done_q.pop_front();
        end
        check("tag_lock", 64'(tag_lock), 64'(exp_lock(cyc)));
        check("busy", 64'(busy), 64'(exp_busy(cyc)));
        check("cfg_ready", 64'(cfg_ready), 64'(!rst && !exp_busy(cyc)));
        check("tag_in_hold", 64'(tag_in), 64'(exp_tag_in));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k, input bit abort_pulse);
        for (int i = 0; i < k; i++) begin
            cfg_valid = 1'b0;
            abort     = abort_pulse && (i == 0);
            tick();
        end
        abort = 1'b0;
    endtask

    // Runs one job from acceptance in the current cycle until it is back in
    // IDLE. abort_rel selects the job-relative cycle of an abort (-1: none).
    task automatic run_job(input int n, input int h, input logic [31:0] base,
                           input logic [7:0] mask, input int abort_rel,
                           input bit abort_at_accept, input bit hold_valid);
        int len;
        cfg_valid    = 1'b1;
        cfg_num_tags = 16'(n);
        cfg_hold     = 16'(h);
        cfg_base_tag = base;
        cfg_col_mask = mask;
        abort        = abort_at_accept;
        model_accept(cyc, n, h, base, mask);
        len = done_offset(n, h);
        for (int r = 1; r <= len; r++) begin
            tick();
            abort = 1'b0;
            if (hold_valid && r < len) begin
                // Descriptor that must be ignored while the job runs.
                cfg_valid    = 1'b1;
                cfg_num_tags = 16'($urandom_range(1, 4));
                cfg_hold     = 16'($urandom_range(0, 2));
                cfg_base_tag = $urandom;
                cfg_col_mask = 8'($urandom);
            end else begin
                cfg_valid = 1'b0;
            end
            if (r == abort_rel) begin
                abort = 1'b1;
                model_abort(cyc);
                tick();
                abort     = 1'b0;
                cfg_valid = 1'b0;
                return;
            end
        end
        tick();
        abort     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n, h, len, ab;
        logic [31:0] base;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed jobs.
        run_job(3, 1, 32'h0000_0010, 8'hFF, -1, 1'b0, 1'b0);
        run_job(4, 0, 32'h0000_0000, 8'hA5, -1, 1'b0, 1'b0);
        run_job(2, 0, 32'hFFFF_FFFF, 8'h3C, -1, 1'b0, 1'b0);
        idle(3, 1'b1);
        run_job(0, 2, 32'h0000_0055, 8'h0F, -1, 1'b0, 1'b0);
        run_job(3, 1, 32'h0000_0010, 8'hFF, 4, 1'b0, 1'b1);
        run_job(1, 0, 32'h0000_0007, 8'h01, -1, 1'b1, 1'b0);

        // Reset in the middle of a HOLD cycle.
        cfg_valid    = 1'b1;
        cfg_num_tags = 16'd3;
        cfg_hold     = 16'd1;
        cfg_base_tag = 32'h0000_0010;
        cfg_col_mask = 8'hFF;
        model_accept(cyc, 3, 1, 32'h0000_0010, 8'hFF);
        tick();
        cfg_valid = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_tag_lock", 64'(tag_lock), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tag_in", 64'(tag_in), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        run_job(3, 1, 32'h0000_0010, 8'hFF, -1, 1'b0, 1'b0);

        // Randomised jobs.
        for (int j = 0; j < 40; j++) begin
            n = $urandom_range(0, 5);
            h = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else base = $urandom;
            len = done_offset(n, h);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : -1;
            run_job(n, h, base, 8'($urandom), ab, ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0));
            idle($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        idle(4, 1'b0);
        check("flush_queue_empty", 64'(flush_q.size()), 64'd0);
        check("done_queue_empty", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
